// File: rtl/spi_ram_burst_if.sv
// Word-level link between the SPI slave core and the RAM back end.
// The master side is the SPI core (rx words in, tx words out); the slave side is the RAM.
interface spi_ram_burst_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH+1:0] din;
    logic                  rx_valid;
    logic                  tx_ready;
    logic [DATA_WIDTH-1:0] dout;
    logic                  tx_valid;
    logic                  busy;
    logic                  cmd_drop;

    modport master (
        output din, rx_valid, tx_ready,
        input  dout, tx_valid, busy, cmd_drop
    );

    modport slave (
        input  din, rx_valid, tx_ready,
        output dout, tx_valid, busy, cmd_drop
    );
endinterface

// File: rtl/spi_ram_burst.sv
// RAM back end for the SPI slave: decodes 2-bit-opcode command words and streams
// multi-word burst reads to the tx path under a valid/ready handshake.
module spi_ram_burst #(
    parameter int MEM_DEPTH  = 256,
    parameter int ADDR_SIZE  = 8,
    parameter int DATA_WIDTH = 8,
    parameter bit AUTO_INC   = 1'b1
) (
    input  logic           clk,
    input  logic           rst_n,
    spi_ram_burst_if.slave bus
);

    typedef enum logic [1:0] {
        OP_WADDR = 2'b00,
        OP_WDATA = 2'b01,
        OP_RADDR = 2'b10,
        OP_READ  = 2'b11
    } opcode_e;

    typedef enum logic {
        IDLE,
        READ
    } state_e;

    localparam logic [ADDR_SIZE-1:0] LAST_ADDR = ADDR_SIZE'(MEM_DEPTH - 1);

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    state_e                state;
    logic [ADDR_SIZE-1:0]  write_address;
    logic [ADDR_SIZE-1:0]  read_address;
    logic [DATA_WIDTH-1:0] remaining;
    logic [DATA_WIDTH-1:0] dout_q;
    logic                  tx_valid_q;
    logic                  busy_q;
    logic                  cmd_drop_q;

    opcode_e               opcode;
    logic [DATA_WIDTH-1:0] payload;
    logic [ADDR_SIZE-1:0]  cmd_addr;
    logic                  mem_we;

    assign opcode   = opcode_e'(bus.din[DATA_WIDTH+1:DATA_WIDTH]);
    assign payload  = bus.din[DATA_WIDTH-1:0];
    assign cmd_addr = payload[ADDR_SIZE-1:0];
    assign mem_we   = (state == IDLE) && bus.rx_valid && (opcode == OP_WDATA);

    // Addresses wrap at the memory depth, which may be smaller than 2**ADDR_SIZE.
    function automatic logic [ADDR_SIZE-1:0] next_addr(input logic [ADDR_SIZE-1:0] a);
        return (a == LAST_ADDR) ? '0 : a + 1'b1;
    endfunction

    // NOTE: the storage array has no reset branch; clearing it would force a flop
    // array instead of a RAM macro, and software never relies on power-up contents.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[write_address] <= payload;
        end
    end

    // NOTE: all state updates use non-blocking assignments so every register samples
    // the pre-edge values, e.g. dout reads the old read_address while it increments.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            write_address <= '0;
            read_address  <= '0;
            remaining     <= '0;
            dout_q        <= '0;
            tx_valid_q    <= 1'b0;
            busy_q        <= 1'b0;
            cmd_drop_q    <= 1'b0;
        end else begin
            cmd_drop_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.rx_valid) begin
                        case (opcode)
                            OP_WADDR: write_address <= cmd_addr;
                            OP_WDATA: begin
                                if (AUTO_INC) begin
                                    write_address <= next_addr(write_address);
                                end
                            end
                            OP_RADDR: read_address <= cmd_addr;
                            OP_READ: begin
                                dout_q       <= mem[read_address];
                                tx_valid_q   <= 1'b1;
                                read_address <= next_addr(read_address);
                                remaining    <= payload;
                                busy_q       <= 1'b1;
                                state        <= READ;
                            end
                        endcase
                    end
                end
                READ: begin
                    // Commands arriving mid-burst, including on the final handshake, are discarded.
                    if (bus.rx_valid) begin
                        cmd_drop_q <= 1'b1;
                    end
                    if (bus.tx_ready) begin
                        if (remaining == '0) begin
                            tx_valid_q <= 1'b0;
                            busy_q     <= 1'b0;
                            state      <= IDLE;
                        end else begin
                            dout_q       <= mem[read_address];
                            read_address <= next_addr(read_address);
                            remaining    <= remaining - 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    assign bus.dout     = dout_q;
    assign bus.tx_valid = tx_valid_q;
    assign bus.busy     = busy_q;
    assign bus.cmd_drop = cmd_drop_q;

endmodule

// File: tb/tb_spi_ram_burst.sv
// Directed bench for spi_ram_burst: one auto-increment instance carries most scenarios,
// a second instance with AUTO_INC=0 covers the write-address hold behaviour.
module tb_spi_ram_burst;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    spi_ram_burst_if #(.DATA_WIDTH(8)) bus  ();
    spi_ram_burst_if #(.DATA_WIDTH(8)) bus2 ();

    spi_ram_burst #(
        .MEM_DEPTH(256), .ADDR_SIZE(8), .DATA_WIDTH(8), .AUTO_INC(1'b1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    spi_ram_burst #(
        .MEM_DEPTH(256), .ADDR_SIZE(8), .DATA_WIDTH(8), .AUTO_INC(1'b0)
    ) dut_hold (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled on the falling edge.
    task automatic cmd(input logic [1:0] op, input logic [7:0] pl);
        bus.din      = {op, pl};
        bus.rx_valid = 1'b1;
        @(negedge clk);
        bus.rx_valid = 1'b0;
    endtask

    task automatic cmd2(input logic [1:0] op, input logic [7:0] pl);
        bus2.din      = {op, pl};
        bus2.rx_valid = 1'b1;
        @(negedge clk);
        bus2.rx_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        bus.din = '0;  bus.rx_valid = 1'b0;  bus.tx_ready = 1'b1;
        bus2.din = '0; bus2.rx_valid = 1'b0; bus2.tx_ready = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        checks++; if (bus.dout !== 8'h00) begin errors++; $display("FAIL reset_dout: got %h expected 00", bus.dout); end
        checks++; if (bus.tx_valid !== 1'b0) begin errors++; $display("FAIL reset_tx_valid: got %b expected 0", bus.tx_valid); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
        checks++; if (bus.cmd_drop !== 1'b0) begin errors++; $display("FAIL reset_cmd_drop: got %b expected 0", bus.cmd_drop); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single();
        bus.tx_ready = 1'b1;
        cmd(2'b00, 8'h10);
        cmd(2'b01, 8'hAA);
        cmd(2'b01, 8'hBB);
        cmd(2'b10, 8'h10);
        checks++; if (bus.tx_valid !== 1'b0) begin errors++; $display("FAIL single_idle_valid: got %b expected 0", bus.tx_valid); end
        cmd(2'b11, 8'h00);
        checks++; if (bus.dout !== 8'hAA) begin errors++; $display("FAIL single_dout: got %h expected aa", bus.dout); end
        checks++; if (bus.tx_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b expected 1", bus.tx_valid); end
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b expected 1", bus.busy); end
        @(negedge clk);
        checks++; if (bus.tx_valid !== 1'b0) begin errors++; $display("FAIL single_end_valid: got %b expected 0", bus.tx_valid); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL single_end_busy: got %b expected 0", bus.busy); end
        checks++; if (bus.dout !== 8'hAA) begin errors++; $display("FAIL single_dout_hold: got %h expected aa", bus.dout); end
    endtask

    task automatic test_burst();
        bus.tx_ready = 1'b1;
        cmd(2'b01, 8'hCC);              // write_address is 0x12 after the two earlier writes
        cmd(2'b10, 8'h10);
        cmd(2'b11, 8'h01);
        checks++; if (bus.dout !== 8'hAA) begin errors++; $display("FAIL burst_w0: got %h expected aa", bus.dout); end
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL burst_busy0: got %b expected 1", bus.busy); end
        @(negedge clk);
        checks++; if (bus.dout !== 8'hBB) begin errors++; $display("FAIL burst_w1: got %h expected bb", bus.dout); end
        checks++; if (bus.tx_valid !== 1'b1) begin errors++; $display("FAIL burst_valid1: got %b expected 1", bus.tx_valid); end
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL burst_busy1: got %b expected 1", bus.busy); end
        @(negedge clk);
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL burst_end_busy: got %b expected 0", bus.busy); end
        cmd(2'b11, 8'h00);
        checks++; if (bus.dout !== 8'hCC) begin errors++; $display("FAIL burst_continue: got %h expected cc", bus.dout); end
        @(negedge clk);
        checks++; if (bus.tx_valid !== 1'b0) begin errors++; $display("FAIL burst_continue_end: got %b expected 0", bus.tx_valid); end
    endtask

    task automatic test_backpressure();
        cmd(2'b10, 8'h10);
        bus.tx_ready = 1'b0;
        cmd(2'b11, 8'h01);
        for (int i = 0; i < 3; i++) begin
            checks++; if (bus.dout !== 8'hAA) begin errors++; $display("FAIL bp_hold_dout[%0d]: got %h expected aa", i, bus.dout); end
            checks++; if (bus.tx_valid !== 1'b1) begin errors++; $display("FAIL bp_hold_valid[%0d]: got %b expected 1", i, bus.tx_valid); end
            @(negedge clk);
        end
        checks++; if (bus.dout !== 8'hAA) begin errors++; $display("FAIL bp_after_stall: got %h expected aa", bus.dout); end
        bus.tx_ready = 1'b1;
        @(negedge clk);
        checks++; if (bus.dout !== 8'hBB) begin errors++; $display("FAIL bp_second: got %h expected bb", bus.dout); end
        checks++; if (bus.tx_valid !== 1'b1) begin errors++; $display("FAIL bp_second_valid: got %b expected 1", bus.tx_valid); end
        @(negedge clk);
        checks++; if (bus.tx_valid !== 1'b0) begin errors++; $display("FAIL bp_end_valid: got %b expected 0", bus.tx_valid); end
        checks++; if (bus.dout !== 8'hBB) begin errors++; $display("FAIL bp_end_dout: got %h expected bb", bus.dout); end
    endtask

    task automatic test_wrap();
        bus.tx_ready = 1'b1;
        cmd(2'b00, 8'hFF);
        cmd(2'b01, 8'h5A);
        cmd(2'b01, 8'h77);
        cmd(2'b10, 8'hFF);
        cmd(2'b11, 8'h01);
        checks++; if (bus.dout !== 8'h5A) begin errors++; $display("FAIL wrap_w0: got %h expected 5a", bus.dout); end
        @(negedge clk);
        checks++; if (bus.dout !== 8'h77) begin errors++; $display("FAIL wrap_w1: got %h expected 77", bus.dout); end
        @(negedge clk);
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL wrap_end_busy: got %b expected 0", bus.busy); end
    endtask

    task automatic test_no_auto_inc();
        bus2.tx_ready = 1'b1;
        cmd2(2'b00, 8'hFF);
        cmd2(2'b01, 8'h5A);
        cmd2(2'b01, 8'h77);
        cmd2(2'b10, 8'hFF);
        cmd2(2'b11, 8'h00);
        checks++; if (bus2.dout !== 8'h77) begin errors++; $display("FAIL hold_overwrite: got %h expected 77", bus2.dout); end
        checks++; if (bus2.tx_valid !== 1'b1) begin errors++; $display("FAIL hold_valid: got %b expected 1", bus2.tx_valid); end
        @(negedge clk);
    endtask

    task automatic test_cmd_drop();
        bus.tx_ready = 1'b1;
        cmd(2'b00, 8'h20);
        cmd(2'b01, 8'h01);
        cmd(2'b01, 8'h02);
        cmd(2'b01, 8'h03);
        cmd(2'b01, 8'h04);              // write_address now 0x24
        cmd(2'b10, 8'h20);
        cmd(2'b11, 8'h03);
        checks++; if (bus.dout !== 8'h01) begin errors++; $display("FAIL drop_w0: got %h expected 01", bus.dout); end
        cmd(2'b00, 8'h33);              // discarded mid-burst
        checks++; if (bus.cmd_drop !== 1'b1) begin errors++; $display("FAIL drop_pulse: got %b expected 1", bus.cmd_drop); end
        checks++; if (bus.dout !== 8'h02) begin errors++; $display("FAIL drop_w1: got %h expected 02", bus.dout); end
        @(negedge clk);
        checks++; if (bus.cmd_drop !== 1'b0) begin errors++; $display("FAIL drop_pulse_end: got %b expected 0", bus.cmd_drop); end
        checks++; if (bus.dout !== 8'h03) begin errors++; $display("FAIL drop_w2: got %h expected 03", bus.dout); end
        @(negedge clk);
        checks++; if (bus.dout !== 8'h04) begin errors++; $display("FAIL drop_w3: got %h expected 04", bus.dout); end
        cmd(2'b01, 8'hEE);              // arrives with the final handshake: still discarded
        checks++; if (bus.cmd_drop !== 1'b1) begin errors++; $display("FAIL drop_last_pulse: got %b expected 1", bus.cmd_drop); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL drop_end_busy: got %b expected 0", bus.busy); end
        cmd(2'b01, 8'h99);              // lands at the untouched write_address 0x24
        cmd(2'b10, 8'h24);
        cmd(2'b11, 8'h00);
        checks++; if (bus.dout !== 8'h99) begin errors++; $display("FAIL drop_waddr_kept: got %h expected 99", bus.dout); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_burst();
        bus.tx_ready = 1'b1;
        cmd(2'b10, 8'h20);
        cmd(2'b11, 8'h03);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (bus.dout !== 8'h00) begin errors++; $display("FAIL midrst_dout: got %h expected 00", bus.dout); end
        checks++; if (bus.tx_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b expected 0", bus.tx_valid); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b expected 0", bus.busy); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        cmd(2'b10, 8'h20);
        cmd(2'b11, 8'h01);
        checks++; if (bus.dout !== 8'h01) begin errors++; $display("FAIL midrst_keep0: got %h expected 01", bus.dout); end
        @(negedge clk);
        checks++; if (bus.dout !== 8'h02) begin errors++; $display("FAIL midrst_keep1: got %h expected 02", bus.dout); end
        @(negedge clk);
        checks++; if (bus.tx_valid !== 1'b0) begin errors++; $display("FAIL midrst_end_valid: got %b expected 0", bus.tx_valid); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_single();
        test_burst();
        test_backpressure();
        test_wrap();
        test_no_auto_inc();
        test_cmd_drop();
        test_reset_mid_burst();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1);
    end

endmodule
